// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

    localparam int         STATE_W  = 2;
    localparam logic [7:0] CNT8_MAX = 8'hFF;

    // Encodings are visible on state_o, so they are fixed explicitly.
    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchroniser that brings the asynchronous PLL LOCK into clk.
module pll_lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the raw input through the chain; the last stage is the safe copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL lock/reset sequencer: pulses PLL RESET, waits for lock, requires lock to
// stay up for STABLE_CYCLES before releasing the downstream reset, and restarts
// the whole sequence on lock loss.
// Build option: define PLL_SEQ_LOSS_COUNT_EN to build the lock-loss counter;
// otherwise loss_count is tied to zero.
//
//   state        | meaning
//   -------------+-------------------------------------------------------
//   ST_PLL_RST   | pll_reset high for RST_CYCLES cycles
//   ST_WAIT_LOCK | waiting up to LOCK_TIMEOUT cycles for synchronised lock
//   ST_STABLE    | lock seen; must hold for STABLE_CYCLES consecutive cycles
//   ST_RUN       | sys_rst_n released, locked high; lock drop restarts
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 27000,
    parameter int STABLE_CYCLES = 2700,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic               sys_rst_n,
    output logic               locked,
    output logic [STATE_W-1:0] state_o,
    output logic [7:0]         fail_count,
    output logic [7:0]         loss_count
);

    localparam logic [CNT_W-1:0] C_RST_TC    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_STABLE_TC = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic             w_fail_evt;
    logic             w_lock_s;
    logic             r_pll_reset;
    logic             r_sys_rst_n;
    logic             r_locked;
    logic [7:0]       r_fail_count;

    pll_lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (pll_lock),
        .o_sync  (w_lock_s)
    );

    // Next-state and shared timer logic; lock events take priority over timer terminals.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_fail_evt  = 1'b0;
        case (r_state)
            ST_PLL_RST: begin
                if (r_timer == C_RST_TC) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + C_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = ST_STABLE;
                    w_timer_nxt = '0;
                end else if (r_timer == C_TIMEOUT_TC) begin
                    w_state_nxt = ST_PLL_RST;
                    w_timer_nxt = '0;
                    w_fail_evt  = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + C_ONE;
                end
            end
            ST_STABLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_timer_nxt = '0;
                end else if (r_timer == C_STABLE_TC) begin
                    w_state_nxt = ST_RUN;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + C_ONE;
                end
            end
            ST_RUN: begin
                w_timer_nxt = '0;
                if (!w_lock_s) begin
                    w_state_nxt = ST_PLL_RST;
                end
            end
            default: begin
                w_state_nxt = ST_PLL_RST;
                w_timer_nxt = '0;
            end
        endcase
    end

    // State, timer and outputs are registered from the next state so they change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_PLL_RST;
            r_timer      <= '0;
            r_pll_reset  <= 1'b1;
            r_sys_rst_n  <= 1'b0;
            r_locked     <= 1'b0;
            r_fail_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_pll_reset <= (w_state_nxt == ST_PLL_RST);
            r_sys_rst_n <= (w_state_nxt == ST_RUN);
            r_locked    <= (w_state_nxt == ST_RUN);
            if (w_fail_evt && (r_fail_count != CNT8_MAX)) begin
                r_fail_count <= r_fail_count + 8'd1;
            end
        end
    end

`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic       w_loss_evt;
    logic [7:0] r_loss_count;

    assign w_loss_evt = (r_state == ST_RUN) && !w_lock_s;

    // Saturating count of lock drops seen while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_count <= '0;
        end else if (w_loss_evt && (r_loss_count != CNT8_MAX)) begin
            r_loss_count <= r_loss_count + 8'd1;
        end
    end

    assign loss_count = r_loss_count;
`else
    assign loss_count = 8'd0;
`endif

    assign pll_reset  = r_pll_reset;
    assign sys_rst_n  = r_sys_rst_n;
    assign locked     = r_locked;
    assign state_o    = r_state;
    assign fail_count = r_fail_count;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: phase/duration reference model
// checked every cycle, plus hand-computed timing checks and random lock traffic.
module tb_pll_reset_sequencer;

    localparam int P_RST    = 4;
    localparam int P_TO     = 20;
    localparam int P_STABLE = 8;
    localparam int P_SYNC   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       locked;
    logic [1:0] state_o;
    logic [7:0] fail_count;
    logic [7:0] loss_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: phase 0=reset pulse, 1=wait lock, 2=stable, 3=run
    int m_phase;
    int m_elapsed;
    int m_fail;
    int m_loss;
    int m_hist [P_SYNC];

    pll_reset_sequencer #(
        .RST_CYCLES    (P_RST),
        .LOCK_TIMEOUT  (P_TO),
        .STABLE_CYCLES (P_STABLE),
        .SYNC_STAGES   (P_SYNC),
        .CNT_W         (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .sys_rst_n  (sys_rst_n),
        .locked     (locked),
        .state_o    (state_o),
        .fail_count (fail_count),
        .loss_count (loss_count)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_loss(input int cnt);
`ifdef PLL_SEQ_LOSS_COUNT_EN
        return cnt;
`else
        return 0 * cnt;
`endif
    endfunction

    task automatic m_reset();
        m_phase   = 0;
        m_elapsed = 0;
        m_fail    = 0;
        m_loss    = 0;
        for (int i = 0; i < P_SYNC; i++) m_hist[i] = 0;
    endtask

    // One clock of the model, in terms of how long each phase has lasted.
    task automatic m_step();
        int ls;
        ls = m_hist[P_SYNC-1];
        for (int i = P_SYNC-1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = int'(pll_lock);
        case (m_phase)
            0: begin
                m_elapsed++;
                if (m_elapsed == P_RST) begin m_phase = 1; m_elapsed = 0; end
            end
            1: begin
                if (ls == 1) begin
                    m_phase = 2; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == P_TO) begin
                        m_phase = 0; m_elapsed = 0;
                        if (m_fail < 255) m_fail++;
                    end
                end
            end
            2: begin
                if (ls == 0) begin
                    m_phase = 1; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == P_STABLE) begin m_phase = 3; m_elapsed = 0; end
                end
            end
            default: begin
                if (ls == 0) begin
                    m_phase = 0; m_elapsed = 0;
                    if (m_loss < 255) m_loss++;
                end
            end
        endcase
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("pll_reset",  int'(pll_reset),  int'(m_phase == 0));
            check("sys_rst_n",  int'(sys_rst_n),  int'(m_phase == 3));
            check("locked",     int'(locked),     int'(m_phase == 3));
            check("state_o",    int'(state_o),    m_phase);
            check("fail_count", int'(fail_count), m_fail);
            check("loss_count", int'(loss_count), exp_loss(m_loss));
        end
    end

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic count_level(input logic lvl, output int n);
        n = 0;
        while ((pll_reset == lvl) && (n < 64)) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic cycles_until_sys(input logic lvl, output int k);
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (sys_rst_n == lvl) break;
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;

        // reset values while rst_n is low
        repeat (2) @(negedge clk);
        check("rst_pll_reset", int'(pll_reset), 1);
        check("rst_sys_rst_n", int'(sys_rst_n), 0);
        check("rst_state", int'(state_o), 0);

        // basic lock
        do_reset();
        count_level(1'b1, n);
        check("basic_pulse_len", n, 4);
        repeat (5) @(negedge clk);
        #1 pll_lock = 1'b1;
        cycles_until_sys(1'b1, k);
        check("basic_lock_latency", k, 11);
        check("basic_state_run", int'(state_o), 3);
        check("basic_locked", int'(locked), 1);

        // lock bounce inside STABLE, then loss in RUN
        do_reset();
        count_level(1'b1, n);
        repeat (5) @(negedge clk);
        #1 pll_lock = 1'b1;
        repeat (5) @(negedge clk);
        #1 pll_lock = 1'b0;
        @(negedge clk);
        #1 pll_lock = 1'b1;
        cycles_until_sys(1'b1, k);
        check("bounce_latency_from_second_rise", k, 11);
        repeat (4) @(negedge clk);
        #1 pll_lock = 1'b0;
        cycles_until_sys(1'b0, k);
        check("loss_latency", k, 3);
        check("loss_locked", int'(locked), 0);
        check("loss_pll_reset", int'(pll_reset), 1);
        check("loss_count_one", int'(loss_count), exp_loss(1));
        count_level(1'b1, n);
        check("loss_pulse_len", n, 4);

        // lock timeout and fail_count saturation
        do_reset();
        count_level(1'b1, n);
        check("to_first_pulse", n, 4);
        count_level(1'b0, n);
        check("to_wait_len", n, 20);
        check("to_fail_one", int'(fail_count), 1);
        count_level(1'b1, n);
        check("to_repulse_len", n, 4);
        repeat (300 * (P_RST + P_TO)) @(negedge clk);
        check("to_fail_sat", int'(fail_count), 255);

        // async reset while in STABLE
        do_reset();
        count_level(1'b1, n);
        repeat (3) @(negedge clk);
        #1 pll_lock = 1'b1;
        repeat (5) @(negedge clk);
        check("ar_in_stable", int'(state_o), 2);
        #1 rst_n = 1'b0;
        #1;
        check("ar_pll_reset", int'(pll_reset), 1);
        check("ar_sys_rst_n", int'(sys_rst_n), 0);
        check("ar_state", int'(state_o), 0);
        check("ar_fail_clear", int'(fail_count), 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        count_level(1'b1, n);
        check("ar_pulse_len", n, 4);

        // randomized lock traffic with occasional resets
        begin
            int run_len;
            run_len = 0;
            for (int c = 0; c < 5000; c++) begin
                @(negedge clk);
                #1;
                if ($urandom_range(0, 399) == 0) begin
                    rst_n = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    #1 rst_n = 1'b1;
                end
                if (run_len == 0) begin
                    pll_lock = ~pll_lock;
                    run_len  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                           : $urandom_range(4, 40);
                end
                run_len--;
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
